// File: rtl/srl_dyn_bit.sv
// One bit of the dynamic delay line: a Depth-deep, CE-gated shift register
// with no reset so it maps onto SRL primitives, plus a programmable tap.
module srl_dyn_bit #(
  parameter int DepthLog2 = 6
) (
  input  logic                 CLK,
  input  logic                 CE,
  input  logic [DepthLog2-1:0] A,
  input  logic                 D,
  output logic                 Q,
  output logic                 Q_LAST
);

  localparam int Depth = 2 ** DepthLog2;

  logic [Depth-1:0] sr;

  always_ff @(posedge CLK) begin
    if (CE) begin
      sr <= {sr[Depth-2:0], D};
    end
  end

  assign Q      = sr[A];
  assign Q_LAST = sr[Depth-1];

endmodule

// File: rtl/srl_dyn_delay.sv
// Bus delay line with a run-time tap, a resettable valid pipeline, an optional
// output register and masking of O_VALID while a tap change settles.
module srl_dyn_delay #(
  parameter int Width     = 16,
  parameter int DepthLog2 = 6,
  parameter bit OutReg    = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CE,
  input  logic [DepthLog2-1:0] DLY,
  input  logic [Width-1:0]     I,
  input  logic                 I_VALID,
  output logic [Width-1:0]     O,
  output logic                 O_VALID,
  output logic [Width-1:0]     Q_LAST,
  output logic                 SETTLING
);

  localparam int Depth = 2 ** DepthLog2;
  localparam int CntW  = DepthLog2 + 1;

  logic [Depth-1:0]     vld_sr;
  logic [DepthLog2-1:0] dly_q;
  logic [CntW-1:0]      scnt;
  logic [Width-1:0]     o_raw_p0;
  logic                 vld_raw_p0;

  for (genvar b = 0; b < Width; b++) begin : g_bit
    srl_dyn_bit #(.DepthLog2(DepthLog2)) u_bit (
      .CLK    (CLK),
      .CE     (CE),
      .A      (dly_q),
      .D      (I[b]),
      .Q      (o_raw_p0[b]),
      .Q_LAST (Q_LAST[b])
    );
  end

  // Control: valid pipeline, tap register and settle counter. A tap change
  // (re)loads the counter with the new delay so every sample still in flight
  // under the old tap is masked; counter is one bit wider so Depth fits.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vld_sr <= '0;
      dly_q  <= '0;
      scnt   <= '0;
    end else begin
      if (CE) begin
        vld_sr <= {vld_sr[Depth-2:0], I_VALID};
      end
      dly_q <= DLY;
      if (DLY != dly_q) begin
        scnt <= CntW'(DLY) + CntW'(1);
      end else if (CE && (scnt != '0)) begin
        scnt <= scnt - CntW'(1);
      end
    end
  end

  assign SETTLING   = (scnt != '0);
  assign vld_raw_p0 = vld_sr[dly_q] & ~SETTLING;

  // Stage p1: optional CE-gated output register.
  if (OutReg) begin : g_oreg
    logic [Width-1:0] o_p1;
    logic             vld_p1;

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        o_p1   <= '0;
        vld_p1 <= 1'b0;
      end else if (CE) begin
        o_p1   <= o_raw_p0;
        vld_p1 <= vld_raw_p0;
      end
    end

    assign O       = o_p1;
    assign O_VALID = vld_p1;
  end else begin : g_comb
    assign O       = o_raw_p0;
    assign O_VALID = vld_raw_p0;
  end

endmodule

// File: tb/tb_srl_dyn_delay.sv
// Scoreboard bench for srl_dyn_delay: combinational and registered variants
// driven in parallel and compared against an age-indexed history model.
module tb_srl_dyn_delay;

  localparam int W  = 16;
  localparam int DL = 6;
  localparam int D  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce_i = 1'b0;
  logic [DL-1:0] dly_i = '0;
  logic [W-1:0]  din_i = '0;
  logic          iv_i = 1'b0;

  logic [W-1:0]  o_c, ql_c, o_r, ql_r;
  logic          ov_c, st_c, ov_r, st_r;

  always #5 clk = ~clk;

  srl_dyn_delay #(.Width(W), .DepthLog2(DL), .OutReg(1'b0)) dut_c (
    .CLK(clk), .RST_N(rst_n), .CE(ce_i), .DLY(dly_i), .I(din_i), .I_VALID(iv_i),
    .O(o_c), .O_VALID(ov_c), .Q_LAST(ql_c), .SETTLING(st_c)
  );

  srl_dyn_delay #(.Width(W), .DepthLog2(DL), .OutReg(1'b1)) dut_r (
    .CLK(clk), .RST_N(rst_n), .CE(ce_i), .DLY(dly_i), .I(din_i), .I_VALID(iv_i),
    .O(o_r), .O_VALID(ov_r), .Q_LAST(ql_r), .SETTLING(st_r)
  );

  typedef struct {
    bit           settling;
    bit           vc;
    bit           kc;
    logic [W-1:0] oc;
    bit           vr;
    bit           kr;
    logic [W-1:0] orr;
    bit           kq;
    logic [W-1:0] ql;
  } exp_t;

  exp_t expq[$];

  // Reference model: history of CE-sampled inputs, newest first. Data history
  // survives reset; valid history is forgotten on reset.
  logic [W-1:0] dhist[$];
  bit           vhist[$];
  int           dly_m  = 0;
  int           scnt_m = 0;
  logic [W-1:0] oreg_o = '0;
  bit           oreg_v = 1'b0;
  bit           oreg_k = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic bit hist_valid(input int age);
    return (age < vhist.size()) ? vhist[age] : 1'b0;
  endfunction

  task automatic step(input bit rst, input bit ce, input int dly,
                      input logic [W-1:0] din, input bit iv);
    exp_t         e;
    bit           kraw;
    logic [W-1:0] oraw;
    bit           vraw;
    @(negedge clk);
    rst_n = rst;
    ce_i  = ce;
    dly_i = DL'(dly);
    din_i = din;
    iv_i  = iv;

    kraw = dly_m < dhist.size();
    oraw = kraw ? dhist[dly_m] : '0;
    vraw = hist_valid(dly_m) && (scnt_m == 0);
    if (!rst) begin
      oreg_o = '0; oreg_v = 1'b0; oreg_k = 1'b1;
    end else if (ce) begin
      oreg_o = oraw; oreg_v = vraw; oreg_k = kraw;
    end

    if (ce) begin
      dhist.push_front(din);
      if (dhist.size() > D) void'(dhist.pop_back());
    end
    if (!rst) begin
      vhist.delete();
    end else if (ce) begin
      vhist.push_front(iv);
      if (vhist.size() > D) void'(vhist.pop_back());
    end
    if (!rst)                    scnt_m = 0;
    else if (dly != dly_m)       scnt_m = dly + 1;
    else if (ce && scnt_m > 0)   scnt_m = scnt_m - 1;
    dly_m = rst ? dly : 0;

    e.settling = (scnt_m != 0);
    e.kc       = dly_m < dhist.size();
    e.oc       = e.kc ? dhist[dly_m] : '0;
    e.vc       = hist_valid(dly_m) && !e.settling;
    e.vr       = oreg_v;
    e.kr       = oreg_k;
    e.orr      = oreg_o;
    e.kq       = dhist.size() == D;
    e.ql       = e.kq ? dhist[D-1] : '0;
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  exp_t me;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        me = expq.pop_front();
        chk("settling_c", W'(st_c), W'(me.settling));
        chk("settling_r", W'(st_r), W'(me.settling));
        chk("o_valid_c",  W'(ov_c), W'(me.vc));
        chk("o_valid_r",  W'(ov_r), W'(me.vr));
        if (me.kc) chk("o_c", o_c, me.oc);
        if (me.kr) chk("o_r", o_r, me.orr);
        if (me.kq) begin
          chk("q_last_c", ql_c, me.ql);
          chk("q_last_r", ql_r, me.ql);
        end
      end
    end
  end

  logic [W-1:0] ramp = '0;
  int           cur_dly;

  initial begin
    // Reset, then single A5A5 pulse through DLY=4 once settled.
    repeat (3) step(0, 1, 4, '0, 0);
    repeat (8) step(1, 1, 4, '0, 0);
    step(1, 1, 4, 16'hA5A5, 1);
    repeat (10) step(1, 1, 4, 16'h0000, 0);

    // Ramps at the tap extremes; DLY=63 also fills the whole line.
    for (int k = 0; k < 12; k++)  begin ramp++; step(1, 1, 0, ramp, 1); end
    for (int k = 0; k < 140; k++) begin ramp++; step(1, 1, 63, ramp, 1); end

    // Delay decrease mid-stream.
    for (int k = 0; k < 30; k++) begin ramp++; step(1, 1, 10, ramp, 1); end
    for (int k = 0; k < 20; k++) begin ramp++; step(1, 1, 3, ramp, 1); end

    // CE toggling with a short tap.
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) ramp++;
      step(1, (k % 2 == 0), 2, ramp, 1);
    end

    // One-cycle reset mid-stream, then recovery.
    for (int k = 0; k < 10; k++) begin ramp++; step(1, 1, 5, ramp, 1); end
    ramp++; step(0, 1, 5, ramp, 1);
    for (int k = 0; k < 20; k++) begin ramp++; step(1, 1, 5, ramp, 1); end

    // Back-to-back tap changes 5 -> 9 -> 2.
    for (int k = 0; k < 10; k++) begin ramp++; step(1, 1, 5, ramp, 1); end
    ramp++; step(1, 1, 9, ramp, 1);
    for (int k = 0; k < 15; k++) begin ramp++; step(1, 1, 2, ramp, 1); end

    // Random traffic: occasional tap changes, CE gaps and resets.
    cur_dly = 7;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) cur_dly = $urandom_range(0, D - 1);
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), cur_dly,
           W'($urandom), $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
